// File: rtl/apb_slv_pkg.sv
// Shared widths, FSM state type and register reset value for the APB register slave.
package apb_slv_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = ADDR_W - 2;

    localparam logic [DATA_W-1:0] REG_RESET = 32'h0;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

endpackage

// File: rtl/apb_slv_regbank.sv
// Register storage, byte-lane write logic and read mux for the APB register slave.
// Define APB_SLV_PSTRB_EN to honour pstrb byte lanes; otherwise writes replace the full word.
module apb_slv_regbank
    import apb_slv_pkg::*;
#(
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [STRB_W-1:0]          wr_strb,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [DATA_W-1:0]          rd_data,
    output logic [NUM_REGS*DATA_W-1:0] regs
);

    logic [DATA_W-1:0] mem [NUM_REGS];

`ifndef APB_SLV_PSTRB_EN
    logic unused_strb;
    assign unused_strb = ^wr_strb;
`endif

    // Index compares in loops keep wide word indices away from narrow array selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem[i] <= REG_RESET;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
`ifdef APB_SLV_PSTRB_EN
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) begin
                            mem[i][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
`else
                    mem[i] <= wr_data;
`endif
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = mem[i];
            end
        end
    end

    always_comb begin
        regs = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[DATA_W*i +: DATA_W] = mem[i];
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave: IDLE/ACCESS FSM, wait-state counter, error decode and registered response.
// Byte-lane strobes are honoured only when APB_SLV_PSTRB_EN is defined.
module apb_reg_slave
    import apb_slv_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                       pclk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [DATA_W-1:0]          pwdata,
    input  logic [STRB_W-1:0]          pstrb,
    input  logic [2:0]                 pprot,
    output logic                       pready,
    output logic [DATA_W-1:0]          prdata,
    output logic                       pslverr,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    localparam logic [IDX_W-1:0] REG_LIMIT = IDX_W'(NUM_REGS);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic                ready_d, err_d;
    logic [DATA_W-1:0]   rdata_d;
    logic                wr_en;
    logic [ADDR_W-1:0]   addr_sel;
    logic                write_sel, acc_err;
    logic [DATA_W-1:0]   rd_data;
    logic                unused_prot;

    assign unused_prot = ^pprot;

    // The response is registered, so on the setup edge it is decoded from the live bus.
    assign addr_sel  = (state_q == IDLE) ? paddr  : addr_q;
    assign write_sel = (state_q == IDLE) ? pwrite : write_q;
    assign acc_err   = (addr_sel[1:0] != 2'b00) || (addr_sel[ADDR_W-1:2] >= REG_LIMIT);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            pready  <= ready_d;
            prdata  <= rdata_d;
            pslverr <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        ready_d = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    cnt_d   = WAIT_LOAD;
                    ready_d = (WAIT_LOAD == '0);
                end
            end
            ACCESS: begin
                if (!psel || !penable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (pready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    wr_en   = write_q && !acc_err;
                end else begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    ready_d = (cnt_q == CNT_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase
        if (ready_d) begin
            err_d   = acc_err;
            rdata_d = (!acc_err && !write_sel) ? rd_data : '0;
        end
    end

    apb_slv_regbank #(
        .NUM_REGS(NUM_REGS)
    ) u_regbank (
        .clk     (pclk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (addr_q[ADDR_W-1:2]),
        .wr_data (wdata_q),
        .wr_strb (strb_q),
        .rd_idx  (addr_sel[ADDR_W-1:2]),
        .rd_data (rd_data),
        .regs    (regs_o)
    );

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter NUM_REGS, default 8: number of 32-bit registers, legal range 1..64.
REQ-002 Parameter WAIT_CYCLES, default 1: access-phase wait states inserted before pready, legal range 0..15.
REQ-003 Port pclk, input, 1: single clock; all logic runs on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port paddr, input, 12: byte address.
REQ-006 Ports psel, penable and pwrite, each input, 1: APB control signals.
REQ-007 Port pwdata, input, 32: write data.
REQ-008 Port pstrb, input, 4: byte write strobes.
REQ-009 Port pprot, input, 3: accepted and ignored.
REQ-010 Port pready, output, 1: registered transfer-complete signal.
REQ-011 Port prdata, output, 32: registered read data.
REQ-012 Port pslverr, output, 1: registered error flag.
REQ-013 Port regs_o, output, NUM_REGS*32: flattened register contents; register i occupies bits [32*i+31:32*i].

Function
REQ-014 Register i SHALL decode at byte address 4*i.
REQ-015 An access SHALL be an error when paddr[1:0]!=0 or paddr[11:2]>=NUM_REGS.
REQ-016 FSM states SHALL be IDLE and ACCESS.
REQ-017 IDLE->ACCESS SHALL occur on a sampled setup phase (psel=1, penable=0); on that edge the FSM latches paddr, pwrite, pwdata and pstrb, and loads the wait counter with WAIT_CYCLES.
REQ-018 In ACCESS, the counter SHALL decrement each cycle while it is nonzero.
REQ-019 pready SHALL be driven 1 in the cycle the counter equals 0. With WAIT_CYCLES=0, pready=1 in the first access cycle; with W wait states, pready=1 in access cycle W+1.
REQ-020 Completion SHALL be the edge with psel=1, penable=1 and pready=1; the FSM returns to IDLE on that edge and pready, prdata and pslverr drop to 0 the next cycle.
REQ-021 A setup phase sampled on the cycle after completion SHALL start a new transfer with no idle gap required.
REQ-022 On a legal write completion, the addressed register SHALL be updated, and regs_o SHALL show the new value on the following cycle.
REQ-023 An error write SHALL modify no register.
REQ-024 prdata SHALL carry the addressed register whenever pready=1 on a legal read, and 0 otherwise, including on error and on writes.
REQ-025 pslverr SHALL equal 1 only when pready=1 and the access is an error; it is 0 at all other times.
REQ-026 If psel=0 or penable=0 is sampled in ACCESS before completion, the FSM SHALL abort to IDLE, write nothing and assert pready 0.
REQ-027 Setup-phase signals that change during ACCESS SHALL be ignored; the latched values are used.

Reset
REQ-028 While rst_n=0: FSM=IDLE, counter=0, pready=0, prdata=0, pslverr=0, and every register=0.
REQ-029 Reset assertion mid-transfer SHALL discard the transfer immediately with no register update.
REQ-030 The first setup phase SHALL be recognised on the first rising edge after rst_n deasserts.

Configuration
REQ-031 With APB_SLV_PSTRB_EN defined, a write SHALL update only byte lanes whose pstrb bit is 1. pstrb=0 completes normally and changes nothing.
REQ-032 Without APB_SLV_PSTRB_EN, pstrb SHALL be ignored and every write replaces the full 32-bit word.

Structure
REQ-033 Package apb_slv_pkg SHALL hold: the address width (12), data width (32) and strobe width (4); the FSM state enum {IDLE, ACCESS}; the wait-counter width (4); and the register reset value (32'h0).
REQ-034 Sub-module apb_slv_regbank SHALL hold register storage, byte-lane write logic and the read mux. The FSM, counter and error decode SHALL remain in apb_reg_slave.

Verification
REQ-035 Zero-wait write: WAIT_CYCLES=0, write 0x000 <- 0xDEADBEEF, pstrb=0xF -> pready=1 in the first access cycle, pslverr=0, regs_o[31:0]=0xDEADBEEF the next cycle.
REQ-036 Wait-state read: WAIT_CYCLES=3, read 0x000 after the write in REQ-035 -> pready=0 for 3 access cycles, then 1, with prdata=0xDEADBEEF.
REQ-037 Error decode: with NUM_REGS=8, write 0x020 and then read 0x002 -> both complete with pslverr=1 and prdata=0, and regs_o is unchanged.
REQ-038 Strobes (APB_SLV_PSTRB_EN): register 1 = 0x11223344, write 0x004 <- 0xAABBCCDD with pstrb=0x5 -> register 1 = 0x11BB33DD. Without the macro -> register 1 = 0xAABBCCDD.
REQ-039 Back-to-back with abort: two writes with no idle gap both commit. Then a write with psel dropped in access cycle 1 (WAIT_CYCLES=2) commits nothing.
REQ-040 Reset mid-access: rst_n=0 during a wait state -> pready, prdata and pslverr read 0, all registers read 0, and a subsequent read of 0x000 returns 0.
